// File: rtl/gcd_seq.sv
// gcd_seq: multi-cycle binary (Stein) GCD unit with a start/busy/done handshake.
// Define GCD_LCM_EN to add a restoring divider, a DIV state and the lcm output.
module gcd_seq #(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   c
`ifdef GCD_LCM_EN
    ,
    output logic [2*WIDTH-1:0] lcm
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STRIP,
        S_LOOP,
`ifdef GCD_LCM_EN
        S_DIV,
`endif
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, c_q, c_d;
    logic [KW-1:0]    k_q, k_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] gcd_val;

    // Restore the common power of two stripped in STRIP.
    assign gcd_val = x_q << k_q;

`ifdef GCD_LCM_EN
    // Latched operands are only needed for the quotient and product.
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d, rem_q, rem_d, dq_q, dq_d, dq_next, rem_sub;
    logic [2*WIDTH-1:0] lcm_q, lcm_d;
    logic [WIDTH:0]     rem_sh;
    logic               q_bit;

    // dq holds the dividend and shifts quotient bits in from the right.
    assign rem_sh  = {rem_q, dq_q[WIDTH-1]};
    assign q_bit   = (rem_sh >= {1'b0, res_q});
    assign rem_sub = rem_sh[WIDTH-1:0] - res_q;
    assign dq_next = {dq_q[WIDTH-2:0], q_bit};
    assign lcm     = lcm_q;
`endif

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign c    = c_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        c_d     = c_q;
        done_d  = 1'b0;
`ifdef GCD_LCM_EN
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        lcm_d   = lcm_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d = a;
                    y_d = b;
                    k_d = '0;
`ifdef GCD_LCM_EN
                    a_d = a;
                    b_d = b;
`endif
                    if (a == '0 || b == '0) begin
                        state_d = S_FIN;
                        c_d     = a | b;
                        done_d  = 1'b1;
`ifdef GCD_LCM_EN
                        lcm_d   = '0;
`endif
                    end else begin
                        state_d = S_STRIP;
                    end
                end
            end
            S_STRIP: begin
                if (!x_q[0] && !y_q[0]) begin
                    x_d = x_q >> 1;
                    y_d = y_q >> 1;
                    k_d = k_q + KW'(1);
                end else begin
                    state_d = S_LOOP;
                end
            end
            S_LOOP: begin
                if (x_q == y_q) begin
`ifdef GCD_LCM_EN
                    res_d   = gcd_val;
                    rem_d   = '0;
                    dq_d    = a_q;
                    k_d     = '0;
                    state_d = S_DIV;
`else
                    c_d     = gcd_val;
                    done_d  = 1'b1;
                    state_d = S_FIN;
`endif
                end else if (!x_q[0]) begin
                    x_d = x_q >> 1;
                end else if (!y_q[0]) begin
                    y_d = y_q >> 1;
                end else if (x_q > y_q) begin
                    x_d = (x_q - y_q) >> 1;
                end else begin
                    y_d = (y_q - x_q) >> 1;
                end
            end
`ifdef GCD_LCM_EN
            S_DIV: begin
                // k is free once the result is formed; reuse it as the step count.
                dq_d  = dq_next;
                rem_d = q_bit ? rem_sub : rem_sh[WIDTH-1:0];
                k_d   = k_q + KW'(1);
                if (k_q == KW'(WIDTH - 1)) begin
                    state_d = S_FIN;
                    c_d     = res_q;
                    done_d  = 1'b1;
                    lcm_d   = {{WIDTH{1'b0}}, dq_next} * {{WIDTH{1'b0}}, b_q};
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
`ifdef GCD_LCM_EN
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            lcm_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            c_q     <= c_d;
            done_q  <= done_d;
`ifdef GCD_LCM_EN
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            lcm_q   <= lcm_d;
`endif
        end
    end

endmodule
